cur_blk_pingpong_buf: RTL

Parametrised, double-buffered successor to the single-bank current-block register file in the motion-estimation datapath. Assembles a BLK_DIM×BLK_DIM block of PIX_W-bit pixels from BUS_W-bit write beats into one of two banks, while the other bank is presented to the SAD array. A valid/release handshake gives the consumer a stable block for as long as it needs it, and lets the next block load with no idle gap. An optional contiguous-write mode aborts a partial load when WE drops mid-block.

---
 rtl/cur_blk_pkg.sv | 23 ++
 rtl/cur_blk_pingpong_buf_if.sv | 26 ++
 rtl/cur_blk_bank.sv | 41 ++++
 rtl/cur_blk_pingpong_buf.sv | 114 +++++++++++
 4 files changed

// File: rtl/cur_blk_pkg.sv
// Shared sizing helpers for the ping-pong current-block buffer.
package cur_blk_pkg;

    // Number of bus beats needed to fill one block.
    function automatic int unsigned calc_beats(input int unsigned blk_dim,
                                               input int unsigned pix_w,
                                               input int unsigned bus_w);
        return (blk_dim * blk_dim * pix_w) / bus_w;
    endfunction

    // Beat counter width; never narrower than one bit.
    function automatic int unsigned calc_cnt_w(input int unsigned beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

    // True when a block splits into a whole number of beats.
    function automatic bit blk_cfg_ok(input int unsigned blk_dim,
                                      input int unsigned pix_w,
                                      input int unsigned bus_w);
        return (bus_w != 0) && (((blk_dim * blk_dim * pix_w) % bus_w) == 0);
    endfunction

endpackage

// File: rtl/cur_blk_pingpong_buf_if.sv
// Write-beat and block-presentation handshake of the current-block buffer.
interface cur_blk_pingpong_buf_if #(
    parameter int unsigned BUS_W = 64,
    parameter int unsigned BLK_W = 2048,
    parameter int unsigned CNT_W = 5
);
    logic             WE;
    logic [BUS_W-1:0] DataIN;
    logic             in_ready;
    logic             out_valid;
    logic             out_release;
    logic [BLK_W-1:0] DataOUT;
    logic [CNT_W-1:0] beat_cnt;

    // Producer/consumer side.
    modport master (
        output WE, DataIN, out_release,
        input  in_ready, out_valid, DataOUT, beat_cnt
    );

    // Buffer side.
    modport slave (
        input  WE, DataIN, out_release,
        output in_ready, out_valid, DataOUT, beat_cnt
    );
endinterface

// File: rtl/cur_blk_bank.sv
// One block of storage written one bus beat at a time; beat 0 lands in the MSBs.
module cur_blk_bank #(
    parameter int unsigned BLK_W = 2048,
    parameter int unsigned BUS_W = 64,
    parameter int unsigned BEATS = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [CNT_W-1:0] idx,
    input  logic [BUS_W-1:0] wdata,
    output logic [BLK_W-1:0] data
);
    logic [BUS_W-1:0] mem_q [BEATS];
    logic [BUS_W-1:0] mem_d [BEATS];

    // Next contents: replace only the addressed beat.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[idx] = wdata;
        end
    end

    // Beat storage, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(BEATS); k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Flatten beats into raster order, beat 0 in the MSBs.
    for (genvar k = 0; k < int'(BEATS); k++) begin : g_pack
        assign data[BLK_W-1-k*BUS_W -: BUS_W] = mem_q[k];
    end
endmodule

// File: rtl/cur_blk_pingpong_buf.sv
// Double-buffered current-block register: one bank fills while the other is presented.
module cur_blk_pingpong_buf
    import cur_blk_pkg::*;
#(
    parameter int unsigned BLK_DIM   = 16,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned BUS_W     = 64,
    parameter int unsigned CONTIG_WE = 1
) (
    input logic                    clk,
    input logic                    reset,
    cur_blk_pingpong_buf_if.slave  bus
);
    localparam int unsigned BLK_W = BLK_DIM * BLK_DIM * PIX_W;
    localparam int unsigned BEATS = calc_beats(BLK_DIM, PIX_W, BUS_W);
    localparam int unsigned CNT_W = calc_cnt_w(BEATS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    if (!blk_cfg_ok(BLK_DIM, PIX_W, BUS_W)) begin : g_cfg_check
        $error("cur_blk_pingpong_buf: block width must be a whole number of bus beats");
    end

    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             accept_c;
    logic             last_c;
    logic             release_c;
    logic [1:0]       bank_we_c;
    logic [BLK_W-1:0] bank0_data, bank1_data;

    // Handshake decode and next-state for counter, flags and bank pointers.
    always_comb begin
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        beat_cnt_d = beat_cnt_q;

        accept_c  = bus.WE && !full_q[wr_bank_q];
        last_c    = accept_c && (beat_cnt_q == LAST_IDX);
        release_c = bus.out_release && full_q[rd_bank_q];
        bank_we_c = {accept_c && wr_bank_q, accept_c && !wr_bank_q};

        if (accept_c) begin
            if (last_c) begin
                beat_cnt_d          = '0;
                full_d[wr_bank_q]   = 1'b1;
                wr_bank_d           = !wr_bank_q;
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end else if ((CONTIG_WE != 0) && !bus.WE) begin
            // A gap in a contiguous load abandons the partial block.
            beat_cnt_d = '0;
        end

        // Fill bank is never the full read bank, so this never collides with last_c.
        if (release_c) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    cur_blk_bank #(
        .BLK_W (BLK_W),
        .BUS_W (BUS_W),
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) u_bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (bank_we_c[0]),
        .idx   (beat_cnt_q),
        .wdata (bus.DataIN),
        .data  (bank0_data)
    );

    cur_blk_bank #(
        .BLK_W (BLK_W),
        .BUS_W (BUS_W),
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) u_bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (bank_we_c[1]),
        .idx   (beat_cnt_q),
        .wdata (bus.DataIN),
        .data  (bank1_data)
    );

    // Outputs are direct decodes of registered state.
    assign bus.in_ready  = !full_q[wr_bank_q];
    assign bus.out_valid = full_q[rd_bank_q];
    assign bus.DataOUT   = rd_bank_q ? bank1_data : bank0_data;
    assign bus.beat_cnt  = beat_cnt_q;
endmodule
